// File: rtl/am_audio_out.sv
// Audio back-end after the AM demodulator: DC removal, scaling and saturation
// to OUT_W bits, and a free-running I2S transmitter carrying the same word on L and R.
module am_audio_out #(
  parameter int IN_W     = 18,
  parameter int OUT_W    = 16,
  parameter int DC_SHIFT = 10,
  parameter int BCLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] demod_out,
  input  logic                   demod_clk,
  output logic [OUT_W-1:0]       audio_out,
  output logic                   audio_valid,
  output logic                   overflow,
  output logic                   dac_bclk,
  output logic                   dac_lrclk,
  output logic                   dac_sdata
);

  localparam int ACC_W   = IN_W + DC_SHIFT + 1;
  localparam int DIFF_W  = IN_W + 1;
  localparam int DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int FRAME_W = 2 * OUT_W;

  localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [OUT_W-1:0]         OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]         OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic                     s0_r, s1_r, s2_r;
  logic                     strobe_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  dc_s;
  logic signed [ACC_W-1:0]  x_wide_s;
  logic signed [ACC_W-1:0]  diff_wide_s;
  logic signed [DIFF_W-1:0] diff_s;
  logic signed [DIFF_W-1:0] scaled_s;
  logic [OUT_W-1:0]         sat_s;
  logic                     clip_s;
  logic [DIV_W-1:0]         div_r;
  logic                     bclk_wrap_s;
  logic                     bclk_fall_s;
  logic [4:0]               bit_cnt_r;
  logic [4:0]               n_s;
  logic [FRAME_W-1:0]       frame_r;

  assign strobe_s = s1_r & ~s2_r;

  // Synchronise the sample qualifier and keep one stage of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_r <= 1'b0;
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s0_r <= demod_clk;
      s1_r <= s0_r;
      s2_r <= s1_r;
    end
  end

  // Leaky-integrator DC estimate, the DC-free difference and its scaled form.
  always_comb begin
    dc_s        = acc_r >>> DC_SHIFT;
    x_wide_s    = ACC_W'(demod_out);
    diff_wide_s = x_wide_s - dc_s;
    diff_s      = diff_wide_s[DIFF_W-1:0];
    scaled_s    = diff_s >>> (IN_W - OUT_W);
  end

  // Clamp the scaled difference to the OUT_W signed range and flag clipping.
  always_comb begin
    sat_s  = scaled_s[OUT_W-1:0];
    clip_s = 1'b0;
    if (scaled_s > SAT_MAX) begin
      sat_s  = OUT_MAX;
      clip_s = 1'b1;
    end else if (scaled_s < SAT_MIN) begin
      sat_s  = OUT_MIN;
      clip_s = 1'b1;
    end else begin
      sat_s  = scaled_s[OUT_W-1:0];
      clip_s = 1'b0;
    end
  end

  // Per-sample update of the DC accumulator and the registered audio sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (strobe_s) begin
      acc_r       <= acc_r + ACC_W'(diff_s);
      audio_out   <= sat_s;
      audio_valid <= 1'b1;
      overflow    <= overflow | clip_s;
    end else begin
      audio_valid <= 1'b0;
    end
  end

  assign bclk_wrap_s = (div_r == DIV_LAST);
  assign bclk_fall_s = bclk_wrap_s & dac_bclk;
  assign n_s         = bit_cnt_r + 5'd1;

  // Bit-clock divider: toggle dac_bclk every BCLK_DIV system clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r    <= '0;
      dac_bclk <= 1'b0;
    end else if (bclk_wrap_s) begin
      div_r    <= '0;
      dac_bclk <= ~dac_bclk;
    end else begin
      div_r    <= div_r + DIV_W'(1);
    end
  end

  // I2S shifter. Bit index is 31 - (n-1) = ~bit_cnt; at n=0 the outgoing bit is
  // still taken from the frame being retired, so the R LSB closes the old frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= 5'd0;
      dac_lrclk <= 1'b0;
      dac_sdata <= 1'b0;
      frame_r   <= '0;
    end else if (bclk_fall_s) begin
      bit_cnt_r <= n_s;
      dac_lrclk <= n_s[4];
      dac_sdata <= frame_r[~bit_cnt_r];
      if (n_s == 5'd0) begin
        frame_r <= {audio_out, audio_out};
      end else begin
        frame_r <= frame_r;
      end
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

endmodule

// File: tb/tb_am_audio_out.sv
// Directed self-checking bench for am_audio_out: reset, DC removal, saturation,
// I2S framing, sample hold / mid-frame update and demod_clk edge qualification.
module tb_am_audio_out;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] demod_out;
  logic               demod_clk;
  logic [15:0]        audio_out;
  logic               audio_valid;
  logic               overflow;
  logic               dac_bclk;
  logic               dac_lrclk;
  logic               dac_sdata;

  int passed = 0;
  int checks = 0;

  int          cyc = 0;
  int          lr_last = 0;
  int          lr_period = 0;
  int          valid_cnt = 0;
  int          word_cnt = 0;
  logic [31:0] shreg = 32'd0;
  logic [31:0] last_word = 32'd0;
  logic        prev_lr = 1'b0;

  am_audio_out dut (
    .clk        (clk),
    .rst        (rst),
    .demod_out  (demod_out),
    .demod_clk  (demod_clk),
    .audio_out  (audio_out),
    .audio_valid(audio_valid),
    .overflow   (overflow),
    .dac_bclk   (dac_bclk),
    .dac_lrclk  (dac_lrclk),
    .dac_sdata  (dac_sdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (audio_valid === 1'b1) valid_cnt = valid_cnt + 1;
  end

  always @(posedge dac_lrclk) begin
    lr_period = cyc - lr_last;
    lr_last   = cyc;
  end

  // A word is the bits sampled at n=1..31 followed by the n=0 bit.
  always @(posedge dac_bclk) begin
    shreg = {shreg[30:0], dac_sdata};
    if (dac_lrclk === 1'b0 && prev_lr === 1'b1) begin
      last_word = shreg;
      word_cnt  = word_cnt + 1;
    end
    prev_lr = dac_lrclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input int x);
    @(posedge clk);
    #1;
    demod_out = x[17:0];
    demod_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    demod_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic next_word(output logic [31:0] w);
    int start;
    int k;
    start = word_cnt;
    k = 0;
    while (word_cnt == start && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("word_timeout", 32'(word_cnt != start), 32'd1);
    w = last_word;
  endtask

  task automatic pulse_reset();
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int base;
    int start;
    int k;
    rst = 1'b1;
    demod_out = '0;
    demod_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_valid", 32'(audio_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bclk", 32'(dac_bclk), 32'd0);
    check("rst_lrclk", 32'(dac_lrclk), 32'd0);
    check("rst_sdata", 32'(dac_sdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single step: first sample latency and value.
    @(posedge clk);
    #1;
    demod_out = 18'sd4000;
    demod_clk = 1'b1;
    @(posedge clk);
    #1;
    check("lat_c1", 32'(audio_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_c2", 32'(audio_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_c3", 32'(audio_valid), 32'd1);
    check("step_first", 32'(audio_out), 32'd1000);
    @(posedge clk);
    #1;
    check("valid_one_cycle", 32'(audio_valid), 32'd0);
    demod_clk = 1'b0;
    repeat (3) @(posedge clk);
    send(4000);
    check("step_second", 32'(audio_out), 32'd999);
    for (int i = 0; i < 5999; i++) send(4000);
    check("decay_lt10", 32'($signed(audio_out) < 16'sd10), 32'd1);
    check("decay_nonneg", 32'(audio_out[15]), 32'd0);
    check("decay_no_ovf", 32'(overflow), 32'd0);

    // Saturation and sticky overflow.
    pulse_reset();
    send(131071);
    check("sat_pos", 32'(audio_out), 32'h7FFF);
    check("sat_pos_ovf", 32'(overflow), 32'd0);
    send(-131072);
    check("sat_neg", 32'(audio_out), 32'h8000);
    check("sat_neg_ovf", 32'(overflow), 32'd1);
    send(0);
    check("after_sat", 32'(audio_out), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-run, then restart timing of the bit clock.
    repeat (37) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("arst_audio", 32'(audio_out), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_bclk", 32'(dac_bclk), 32'd0);
    check("arst_lrclk", 32'(dac_lrclk), 32'd0);
    check("arst_sdata", 32'(dac_sdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bclk_low_3", 32'(dac_bclk), 32'd0);
    @(posedge clk);
    #1;
    check("bclk_rise_4", 32'(dac_bclk), 32'd1);

    // I2S framing with audio_out = 0xA5C3 (x = -92404 from a cleared accumulator).
    send(-92404);
    check("frame_src", 32'(audio_out), 32'h0000A5C3);
    repeat (3) next_word(w);
    for (int i = 0; i < 3; i++) begin
      next_word(w);
      check("frame_word", w, 32'hA5C3A5C3);
    end
    check("lrclk_period", 32'(lr_period), 32'd256);

    // New sample while bit_cnt = 8: current frame keeps the old word.
    start = word_cnt;
    k = 0;
    while (word_cnt == start && k < 40) begin
      @(posedge dac_bclk);
      #1;
      k++;
    end
    check("align_timeout", 32'(word_cnt != start), 32'd1);
    repeat (8) @(posedge dac_bclk);
    #1;
    demod_out = 18'sd0;
    demod_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    demod_clk = 1'b0;
    check("mid_sample", 32'(audio_out), 32'h00000016);
    next_word(w);
    check("inflight_word", w, 32'hA5C3A5C3);
    next_word(w);
    check("next_frame_word", w, 32'h00160016);

    // demod_clk held high, then a one-cycle low glitch.
    base = valid_cnt;
    @(posedge clk);
    #1;
    demod_clk = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("hold_high_pulses", 32'(valid_cnt - base), 32'd1);
    demod_clk = 1'b0;
    @(posedge clk);
    #1;
    demod_clk = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    demod_clk = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_pulses", 32'(valid_cnt - base), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
